// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier for the EX-stage mul op.
// Holds the pipeline via Stall while iterating one partial product per cycle.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Hold,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] sum;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    unique case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          acc_d    = '0;
          mcand_d  = A;
          mplier_d = B;
          cnt_d    = CW'(WIDTH);
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // last step: publish the final partial sum directly
        if (cnt_q == CW'(1)) begin
          result_d = sum;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!Hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (Flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign Stall  = ((state_q == S_IDLE) && Start && !Flush) ||
                  ((state_q == S_RUN) && !Flush);
  assign Busy   = (state_q == S_RUN);
  assign Done   = (state_q == S_DONE);
  assign Result = result_q;

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle sequencer for the `mul` R-type instruction (ALUOp 4'b1001) in the EX stage. When the decoder selects `mul`, this block runs a radix-2 shift-add multiply over WIDTH cycles and asserts a stall to hold IF/ID/EX. It releases the stall on the cycle the low-WIDTH product is valid for the EX/MEM register. It replaces a single-cycle combinational multiplier on the critical path and arbitrates the single adder between iterations.

## Interface
- WIDTH, 32, operand and result width in bits; legal range 4..32.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  one clock; reset is synchronous and active-low.
- Start  in  1  level from EX: instruction in EX is `mul` (ALUOp == 4'b1001).
- Hold  in  1  external pipeline stall, for example a memory wait; freezes DONE.
- Flush  in  1  EX flush from branch or jump; aborts any operation.
- A  in  WIDTH  multiplicand, rs value.
- B  in  WIDTH  multiplier, rt value.
- Stall  out  1  hold PC, IF/ID and ID/EX; combinational.
- Busy  out  1  registered; 1 in RUN.
- Done  out  1  registered; 1 in DONE.
- Result  out  WIDTH  registered product, (A*B) mod 2^WIDTH.

## Operation
- States are IDLE, RUN and DONE. Encoding is free.
- Internal registers:
  - acc (WIDTH): the running sum.
  - mcand (WIDTH): shifted left 1 per step.
  - mplier (WIDTH): shifted right 1 per step.
  - cnt: $clog2(WIDTH)+1 bits.
- **IDLE**
  - Start=1 and Flush=0 causes these loads, then goes to RUN: acc←0, mcand←A, mplier←B, cnt←WIDTH.
  - Otherwise the block stays in IDLE.
- **RUN**, on each cycle:
  - If mplier[0]=1, then acc←acc+mcand. Addition is mod 2^WIDTH and the carry is discarded.
  - mcand←mcand<<1 and mplier←mplier>>1 (logical shift); cnt←cnt−1.
  - When cnt==1 before the decrement, the block writes Result←the final acc value and goes to DONE.
- **DONE**
  - Hold=1 keeps the block in DONE.
  - Hold=0 moves it to IDLE.
  - Start is ignored in DONE, because the completing `mul` is still in EX.
- Signedness: the low WIDTH bits of a two's-complement product match the unsigned product. No sign correction is applied, and no overflow flag exists.
- Flush=1 in any state: the next state is IDLE, Busy and Done go to 0, and Result keeps its value. Flush overrides Start and Hold.
- Stall = (state==IDLE & Start & ~Flush) | (state==RUN & ~Flush). Stall is 0 in DONE.
- Result changes only on the RUN→DONE transition and on reset. It holds across IDLE.
- A and B are sampled only on acceptance. Later changes have no effect.

## Timing
- Reset with Rst_n=0 at a rising edge: state=IDLE, Busy=0, Done=0, Result=0, acc=0 and cnt=0. Reset overrides Flush, Start and Hold. Reset mid-RUN aborts with no Done.
- Latency from acceptance (cycle 0, Start high in IDLE):
  - RUN covers cycles 1..WIDTH, with Busy=1.
  - DONE is cycle WIDTH+1, with Done=1 and Result valid.
- Stall runs high for cycles 0..WIDTH, which is WIDTH+1 cycles, and is low in cycle WIDTH+1.
- Back-to-back `mul`: the second `mul` enters EX in cycle WIDTH+2, is seen in IDLE and is accepted in the same cycle. There is no dead cycle.
- Done is high for exactly one cycle, unless Hold extends it; it stays high while Hold=1.
- Start is low in IDLE for a non-`mul` instruction, so Stall=0 and the pipeline sees zero overhead.

## Test plan
- Reset: hold Rst_n=0 for 2 cycles with Start=1 → Stall is 1 combinationally, but state stays IDLE; Busy=0, Done=0, Result=0. Release → accepted on the next edge.
- Basic, WIDTH=32: A=7, B=6 → Stall is high for 33 cycles, Done is high in cycle 33, Result=42.
- Signed and wrap:
  - A=32'hFFFFFFFD (−3), B=5 → Result=32'hFFFFFFF1.
  - A=32'h80000000, B=2 → Result=0.
  - A=B=32'hFFFFFFFF → Result=1.
- Back-to-back: A=3, B=4, then A=10, B=10 with Start held → Done in cycle 33 with Result=12. The second operation is accepted in cycle 34, and Done is in cycle 67 with Result=100.
- Flush mid-RUN: flush in cycle 10 of A=9, B=9 → IDLE next cycle, Busy=0, no Done pulse, and Result keeps the prior value. Start in the following cycle is accepted normally.
- Hold in DONE: Hold=1 for 3 cycles at completion → Done stays high for 4 cycles, Result is stable and Stall=0 throughout. Start=1 during DONE does not retrigger.
